// File: rtl/game_round_ctrl.sv
// Purpose : round sequencer for the switch game. It requests a prompt, times the round,
//           scores matches, runs a break between rounds and ends the game on a timeout.
// Latency : every output is a flop. A tick that changes state updates the outputs on that
//           same clk1Hz edge. prompt_req is held until a tick samples prompt_ack.
// Backpressure: the prompt handshake is req/ack with no timeout. PROMPT waits as long as
//           prompt_ack stays low.
//
// Ports
//   clk1Hz          in   game tick (1 Hz)
//   reset_btn       in   asynchronous, active-high reset
//   start           in   start/restart level. It is acted on only in IDLE and OVER.
//   sw[9:0]         in   live switch positions. They are compared only in PLAY.
//   prompt_ack      in   prompt_expected/prompt_led are valid. Sampled only in PROMPT.
//   prompt_expected in   switch pattern that passes the round
//   prompt_led[9:0] in   LED hint pattern for the round
//   prompt_req      out  asks the prompt generator for a new prompt
//   led_target[9:0] out  latched LED hint. It is 0 outside PLAY.
//   count[5:0]      out  seconds remaining in PLAY/BREAK. It is 0 in every other state.
//   score[13:0]     out  accumulated points. Saturates at SCORE_MAX.
//   rounds[6:0]     out  rounds passed. Saturates at 99.
//   state_o[2:0]    out  FSM state for debug (IDLE=0 PROMPT=1 PLAY=2 BREAK=3 OVER=4)
//   game_over       out  high while in OVER
module game_round_ctrl #(
  parameter int ROUND_TIME = 15,
  parameter int BREAK_TIME = 5,
  parameter int LVL_ROUNDS = 5,
  parameter int MAX_SHIFT  = 4,
  parameter int SCORE_MAX  = 9999
) (
  input  logic        clk1Hz,
  input  logic        reset_btn,
  input  logic        start,
  input  logic [9:0]  sw,
  input  logic        prompt_ack,
  input  logic [9:0]  prompt_expected,
  input  logic [9:0]  prompt_led,
  output logic        prompt_req,
  output logic [9:0]  led_target,
  output logic [5:0]  count,
  output logic [13:0] score,
  output logic [6:0]  rounds,
  output logic [2:0]  state_o,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PROMPT = 3'd1,
    S_PLAY   = 3'd2,
    S_BREAK  = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  // The full round context sits in one packed register.
  // A single reset clause therefore clears all of it.
  typedef struct packed {
    logic [9:0]  expected;
    logic [9:0]  led_target;
    logic [5:0]  count;
    logic [13:0] score;
    logic [6:0]  rounds;
    logic        prompt_req;
    logic        game_over;
  } round_regs_t;

  localparam logic [5:0]  ROUND_CNT   = 6'(ROUND_TIME);
  localparam logic [5:0]  BREAK_CNT   = 6'(BREAK_TIME);
  localparam logic [14:0] SCORE_CAP   = 15'(SCORE_MAX);
  localparam logic [6:0]  ROUNDS_CAP  = 7'd99;

  state_t      state_q;
  state_t      state_d;
  round_regs_t regs_q;
  round_regs_t regs_d;

  logic        sw_match;
  logic [14:0] pts;
  logic [14:0] score_sum;
  logic [13:0] score_inc;
  logic [6:0]  rounds_inc;

  // Points per pass double every LVL_ROUNDS passed rounds.
  // The doubling stops after MAX_SHIFT doublings.
  // The argument is the count of rounds passed before this one.
  function automatic logic [14:0] round_points(input logic [6:0] r);
    int lvl;
    lvl = int'({25'd0, r}) / LVL_ROUNDS;
    if (lvl > MAX_SHIFT) begin
      lvl = MAX_SHIFT;
    end
    return 15'd2 << lvl;
  endfunction

  assign sw_match = (sw == regs_q.expected);
  assign pts      = round_points(regs_q.rounds);

  // The sum has one extra bit, so a carry past 14 bits still clamps correctly.
  assign score_sum  = {1'b0, regs_q.score} + pts;
  assign score_inc  = (score_sum > SCORE_CAP) ? SCORE_CAP[13:0] : score_sum[13:0];
  assign rounds_inc = (regs_q.rounds >= ROUNDS_CAP) ? ROUNDS_CAP : regs_q.rounds + 7'd1;

  // State and datapath registers
  always_ff @(posedge clk1Hz or posedge reset_btn) begin
    if (reset_btn) begin
      state_q <= S_IDLE;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
    end
  end

  // Next-state logic and next value of every registered output
  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;

    case (state_q)
      S_IDLE: begin
        regs_d.count      = '0;
        regs_d.led_target = '0;
        regs_d.prompt_req = 1'b0;
        regs_d.game_over  = 1'b0;
        if (start) begin
          state_d           = S_PROMPT;
          regs_d.score      = '0;
          regs_d.rounds     = '0;
          regs_d.prompt_req = 1'b1;
        end
      end

      S_PROMPT: begin
        regs_d.count      = '0;
        regs_d.led_target = '0;
        regs_d.prompt_req = 1'b1;
        if (prompt_ack) begin
          state_d           = S_PLAY;
          regs_d.expected   = prompt_expected;
          regs_d.led_target = prompt_led;
          regs_d.count      = ROUND_CNT;
          regs_d.prompt_req = 1'b0;
        end
      end

      S_PLAY: begin
        // A match is checked before the timeout.
        // A match on the last second therefore still scores.
        if (sw_match) begin
          state_d           = S_BREAK;
          regs_d.rounds     = rounds_inc;
          regs_d.score      = score_inc;
          regs_d.led_target = '0;
          regs_d.count      = BREAK_CNT;
        end else if (regs_q.count == '0) begin
          state_d           = S_OVER;
          regs_d.led_target = '0;
          regs_d.count      = '0;
          regs_d.game_over  = 1'b1;
        end else begin
          regs_d.count = regs_q.count - 6'd1;
        end
      end

      S_BREAK: begin
        if (regs_q.count != '0) begin
          regs_d.count = regs_q.count - 6'd1;
        end else begin
          state_d           = S_PROMPT;
          regs_d.prompt_req = 1'b1;
        end
      end

      S_OVER: begin
        regs_d.game_over = 1'b1;
        if (start) begin
          state_d           = S_PROMPT;
          regs_d.score      = '0;
          regs_d.rounds     = '0;
          regs_d.game_over  = 1'b0;
          regs_d.prompt_req = 1'b1;
        end
      end

      // Codes 5..7 are unreachable. They are flushed back to IDLE with idle outputs.
      default: begin
        state_d           = S_IDLE;
        regs_d.count      = '0;
        regs_d.led_target = '0;
        regs_d.prompt_req = 1'b0;
        regs_d.game_over  = 1'b0;
      end
    endcase
  end

  assign prompt_req = regs_q.prompt_req;
  assign led_target = regs_q.led_target;
  assign count      = regs_q.count;
  assign score      = regs_q.score;
  assign rounds     = regs_q.rounds;
  assign state_o    = state_q;
  assign game_over  = regs_q.game_over;

endmodule
